// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle main control FSM for the MIPS datapath. It walks each
// instruction through fetch, decode, execute, memory and writeback, and drives
// the ALU operation code, the operand selects and the datapath strobes.
//
// Build option:
//   MULTI_CTRL_BRANCH_EXT_EN - when defined, blez/bgtz/bltz/bgez are decoded.
//                              When undefined, those opcodes trap in DECODE.
//
// The instruction register is external and holds its value for the whole
// instruction, so the later states decode Op_I/Funct_I/Rt_I directly.

`ifndef MUX_ALU_ADD
`define MUX_ALU_ADD   4'd0
`define MUX_ALU_SUB   4'd1
`define MUX_ALU_AND   4'd2
`define MUX_ALU_OR    4'd3
`define MUX_ALU_XOR   4'd4
`define MUX_ALU_NOR   4'd5
`define MUX_ALU_COMP  4'd6
`define MUX_ALU_COMPU 4'd7
`define MUX_ALU_SLL   4'd8
`define MUX_ALU_SRL   4'd9
`define MUX_ALU_SRA   4'd10
`define MUX_ALU_UP    4'd11
`define MUX_ALU_BLEZ  4'd12
`define MUX_ALU_BGTZ  4'd13
`define MUX_ALU_BLTZ  4'd14
`define MUX_ALU_BGEZ  4'd15
`endif

module mips_multicycle_ctrl (
  input  logic       Clk_I,
  input  logic       Rst_n_I,
  input  logic [5:0] Op_I,
  input  logic [5:0] Funct_I,
  input  logic [4:0] Rt_I,
  input  logic       Zero_I,
  input  logic       MemReady_I,
  output logic [3:0] ALUoperation_O,
  output logic [1:0] ALUSrcA_O,
  output logic [2:0] ALUSrcB_O,
  output logic       MemRead_O,
  output logic       MemWrite_O,
  output logic       IorD_O,
  output logic       IRWrite_O,
  output logic       PCWrite_O,
  output logic       RegWrite_O,
  output logic [1:0] PCSource_O,
  output logic [1:0] RegDst_O,
  output logic [1:0] MemtoReg_O,
  output logic       Illegal_O,
  output logic [3:0] State_O
);

`ifdef MULTI_CTRL_BRANCH_EXT_EN
  localparam logic BRANCH_EXT_EN = 1'b1;
`else
  localparam logic BRANCH_EXT_EN = 1'b0;
`endif

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_ALUWB  = 4'd3,
    ST_MEMADR = 4'd4,
    ST_MEMRD  = 4'd5,
    ST_MEMWB  = 4'd6,
    ST_MEMWR  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_TRAP   = 4'd15
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic is_rtype;
  logic is_imm;
  logic is_branch_ext;

  assign is_rtype      = (Op_I == OP_RTYPE);
  assign is_imm        = (Op_I[5:3] == 3'b001);
  assign is_branch_ext = (Op_I == OP_BLEZ) || (Op_I == OP_BGTZ) || (Op_I == OP_REGIMM);

  // State register; a low Rst_n_I restarts at FETCH and abandons any access.
  always_ff @(posedge Clk_I) begin
    if (!Rst_n_I) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode; strobes are forced low while in reset.
  always_comb begin
    state_next     = state_reg;
    ALUoperation_O = `MUX_ALU_ADD;
    ALUSrcA_O      = 2'd0;
    ALUSrcB_O      = 3'd0;
    MemRead_O      = 1'b0;
    MemWrite_O     = 1'b0;
    IorD_O         = 1'b0;
    IRWrite_O      = 1'b0;
    PCWrite_O      = 1'b0;
    RegWrite_O     = 1'b0;
    PCSource_O     = 2'd0;
    RegDst_O       = 2'd0;
    MemtoReg_O     = 2'd0;

    case (state_reg)
      ST_FETCH: begin
        MemRead_O      = 1'b1;
        ALUSrcA_O      = 2'd0;
        ALUSrcB_O      = 3'd1;
        ALUoperation_O = `MUX_ALU_ADD;
        IRWrite_O      = MemReady_I;
        PCWrite_O      = MemReady_I;
        if (MemReady_I) state_next = ST_DECODE;
      end

      ST_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcA_O      = 2'd0;
        ALUSrcB_O      = 3'd3;
        ALUoperation_O = `MUX_ALU_ADD;
        if (is_rtype) begin
          state_next = (Funct_I == FN_JR) ? ST_JUMP : ST_EXEC;
        end else if (is_imm) begin
          state_next = ST_EXEC;
        end else if (Op_I == OP_LW || Op_I == OP_SW) begin
          state_next = ST_MEMADR;
        end else if (Op_I == OP_BEQ || Op_I == OP_BNE) begin
          state_next = ST_BRANCH;
        end else if (is_branch_ext) begin
          state_next = BRANCH_EXT_EN ? ST_BRANCH : ST_TRAP;
        end else if (Op_I == OP_J || Op_I == OP_JAL) begin
          state_next = ST_JUMP;
        end else begin
          state_next = ST_TRAP;
        end
      end

      ST_EXEC: begin
        state_next = ST_ALUWB;
        if (is_rtype) begin
          ALUSrcA_O = 2'd1;
          ALUSrcB_O = 3'd0;
          case (Funct_I)
            FN_ADD, FN_ADDU: ALUoperation_O = `MUX_ALU_ADD;
            FN_SUB, FN_SUBU: ALUoperation_O = `MUX_ALU_SUB;
            FN_AND:          ALUoperation_O = `MUX_ALU_AND;
            FN_OR:           ALUoperation_O = `MUX_ALU_OR;
            FN_XOR:          ALUoperation_O = `MUX_ALU_XOR;
            FN_NOR:          ALUoperation_O = `MUX_ALU_NOR;
            FN_SLT:          ALUoperation_O = `MUX_ALU_COMP;
            FN_SLTU:         ALUoperation_O = `MUX_ALU_COMPU;
            FN_SLL: begin ALUSrcA_O = 2'd2; ALUoperation_O = `MUX_ALU_SLL; end
            FN_SRL: begin ALUSrcA_O = 2'd2; ALUoperation_O = `MUX_ALU_SRL; end
            FN_SRA: begin ALUSrcA_O = 2'd2; ALUoperation_O = `MUX_ALU_SRA; end
            FN_SLLV:         ALUoperation_O = `MUX_ALU_SLL;
            FN_SRLV:         ALUoperation_O = `MUX_ALU_SRL;
            FN_SRAV:         ALUoperation_O = `MUX_ALU_SRA;
            default: begin
              ALUSrcA_O  = 2'd0;
              state_next = ST_TRAP;
            end
          endcase
        end else begin
          ALUSrcA_O = 2'd1;
          case (Op_I)
            OP_ADDI, OP_ADDIU: begin ALUSrcB_O = 3'd2; ALUoperation_O = `MUX_ALU_ADD;   end
            OP_SLTI:           begin ALUSrcB_O = 3'd2; ALUoperation_O = `MUX_ALU_COMP;  end
            OP_SLTIU:          begin ALUSrcB_O = 3'd2; ALUoperation_O = `MUX_ALU_COMPU; end
            OP_ANDI:           begin ALUSrcB_O = 3'd4; ALUoperation_O = `MUX_ALU_AND;   end
            OP_ORI:            begin ALUSrcB_O = 3'd4; ALUoperation_O = `MUX_ALU_OR;    end
            OP_XORI:           begin ALUSrcB_O = 3'd4; ALUoperation_O = `MUX_ALU_XOR;   end
            OP_LUI:            begin ALUSrcB_O = 3'd4; ALUoperation_O = `MUX_ALU_UP;    end
            default: begin
              ALUSrcA_O  = 2'd0;
              state_next = ST_TRAP;
            end
          endcase
        end
      end

      ST_ALUWB: begin
        RegWrite_O = 1'b1;
        MemtoReg_O = 2'd0;
        RegDst_O   = is_rtype ? 2'd1 : 2'd0;
        state_next = ST_FETCH;
      end

      ST_MEMADR: begin
        ALUSrcA_O      = 2'd1;
        ALUSrcB_O      = 3'd2;
        ALUoperation_O = `MUX_ALU_ADD;
        if (Op_I == OP_LW)      state_next = ST_MEMRD;
        else if (Op_I == OP_SW) state_next = ST_MEMWR;
        else                    state_next = ST_TRAP;
      end

      ST_MEMRD: begin
        IorD_O    = 1'b1;
        MemRead_O = 1'b1;
        if (MemReady_I) state_next = ST_MEMWB;
      end

      ST_MEMWR: begin
        IorD_O     = 1'b1;
        MemWrite_O = 1'b1;
        if (MemReady_I) state_next = ST_FETCH;
      end

      ST_MEMWB: begin
        RegWrite_O = 1'b1;
        RegDst_O   = 2'd0;
        MemtoReg_O = 2'd1;
        state_next = ST_FETCH;
      end

      ST_BRANCH: begin
        // The ALU compares rs (against rt or zero) and Zero_I resolves the branch.
        state_next = ST_FETCH;
        case (Op_I)
          OP_BEQ: begin
            ALUSrcA_O = 2'd1; PCSource_O = 2'd1;
            ALUoperation_O = `MUX_ALU_SUB;
            PCWrite_O = Zero_I;
          end
          OP_BNE: begin
            ALUSrcA_O = 2'd1; PCSource_O = 2'd1;
            ALUoperation_O = `MUX_ALU_SUB;
            PCWrite_O = !Zero_I;
          end
          OP_BLEZ: begin
            if (BRANCH_EXT_EN) begin
              ALUSrcA_O = 2'd1; PCSource_O = 2'd1;
              ALUoperation_O = `MUX_ALU_BLEZ;
              PCWrite_O = Zero_I;
            end else begin
              state_next = ST_TRAP;
            end
          end
          OP_BGTZ: begin
            if (BRANCH_EXT_EN) begin
              ALUSrcA_O = 2'd1; PCSource_O = 2'd1;
              ALUoperation_O = `MUX_ALU_BGTZ;
              PCWrite_O = Zero_I;
            end else begin
              state_next = ST_TRAP;
            end
          end
          OP_REGIMM: begin
            if (BRANCH_EXT_EN && (Rt_I == 5'd0 || Rt_I == 5'd1)) begin
              ALUSrcA_O = 2'd1; PCSource_O = 2'd1;
              ALUoperation_O = (Rt_I == 5'd0) ? `MUX_ALU_BLTZ : `MUX_ALU_BGEZ;
              PCWrite_O = Zero_I;
            end else begin
              state_next = ST_TRAP;
            end
          end
          default: state_next = ST_TRAP;
        endcase
      end

      ST_JUMP: begin
        PCWrite_O  = 1'b1;
        PCSource_O = is_rtype ? 2'd3 : 2'd2;
        if (Op_I == OP_JAL) begin
          RegWrite_O = 1'b1;
          RegDst_O   = 2'd2;
          MemtoReg_O = 2'd2;
        end
        state_next = ST_FETCH;
      end

      ST_TRAP: begin
        state_next = ST_TRAP;
      end

      default: begin
        state_next = ST_TRAP;
      end
    endcase

    if (!Rst_n_I) begin
      MemRead_O  = 1'b0;
      MemWrite_O = 1'b0;
      IRWrite_O  = 1'b0;
      PCWrite_O  = 1'b0;
      RegWrite_O = 1'b0;
    end
  end

  // Status outputs straight from the state register.
  assign Illegal_O = (state_reg == ST_TRAP) && Rst_n_I;
  assign State_O   = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl. Inputs change one time unit
// after the rising edge and outputs are checked one more unit later.
module tb_mips_multicycle_ctrl;

  // ALU codes as the controller is expected to drive them
  localparam int ADD = 0, SUB = 1, SLL = 8, BGEZ = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       zero;
  logic       mem_ready;

  logic [3:0] alu_op;
  logic [1:0] src_a;
  logic [2:0] src_b;
  logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic [1:0] pc_source, reg_dst, mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  mips_multicycle_ctrl dut (
    .Clk_I          (clk),
    .Rst_n_I        (rst_n),
    .Op_I           (op),
    .Funct_I        (funct),
    .Rt_I           (rt),
    .Zero_I         (zero),
    .MemReady_I     (mem_ready),
    .ALUoperation_O (alu_op),
    .ALUSrcA_O      (src_a),
    .ALUSrcB_O      (src_b),
    .MemRead_O      (mem_read),
    .MemWrite_O     (mem_write),
    .IorD_O         (iord),
    .IRWrite_O      (ir_write),
    .PCWrite_O      (pc_write),
    .RegWrite_O     (reg_write),
    .PCSource_O     (pc_source),
    .RegDst_O       (reg_dst),
    .MemtoReg_O     (mem_to_reg),
    .Illegal_O      (illegal),
    .State_O        (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_all(input string tag, input int st, input int aop, input int a, input int b,
                            input int mr, input int mw, input int io, input int irw, input int pcw,
                            input int rw, input int pcs, input int rd, input int m2r, input int ill);
    chk({tag, ".state"},    32'(state),      st);
    chk({tag, ".aluop"},    32'(alu_op),     aop);
    chk({tag, ".srca"},     32'(src_a),      a);
    chk({tag, ".srcb"},     32'(src_b),      b);
    chk({tag, ".memread"},  32'(mem_read),   mr);
    chk({tag, ".memwrite"}, 32'(mem_write),  mw);
    chk({tag, ".iord"},     32'(iord),       io);
    chk({tag, ".irwrite"},  32'(ir_write),   irw);
    chk({tag, ".pcwrite"},  32'(pc_write),   pcw);
    chk({tag, ".regwrite"}, 32'(reg_write),  rw);
    chk({tag, ".pcsource"}, 32'(pc_source),  pcs);
    chk({tag, ".regdst"},   32'(reg_dst),    rd);
    chk({tag, ".memtoreg"}, 32'(mem_to_reg), m2r);
    chk({tag, ".illegal"},  32'(illegal),    ill);
  endtask

  // FETCH: read at PC, PC+4 in the ALU, IR/PC written only when memory is ready
  task automatic fetch_chk(input string tag, input int rdy);
    expect_all(tag, 0, ADD, 0, 1, 1, 0, 0, rdy, rdy, 0, 0, 0, 0, 0);
  endtask

  task automatic decode_chk(input string tag);
    expect_all(tag, 1, ADD, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; op = 6'd0; funct = 6'd0; rt = 5'd0; zero = 1'b0; mem_ready = 1'b0;

    // Reset for two cycles; strobes stay low even with MemReady_I high
    tick();
    tick();
    mem_ready = 1'b1;
    #1;
    expect_all("reset", 0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] reset: held 2 cycles, state=%0d", state);

    // add: FETCH -> DECODE -> EXEC -> ALUWB -> FETCH
    rst_n = 1'b1; op = 6'b000000; funct = 6'b100000;
    #1;
    fetch_chk("add.fetch", 1);
    tick(); decode_chk("add.decode");
    tick(); expect_all("add.exec",  2, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); expect_all("add.aluwb", 3, ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tick();
    $display("[TB] add: 4-cycle sequence, back in state %0d", state);

    // lw with three memory wait cycles in MEMRD: 8 cycles total
    op = 6'b100011; funct = 6'd0;
    #1;
    fetch_chk("lw.fetch", 1);
    tick(); decode_chk("lw.decode");
    tick(); expect_all("lw.memadr", 4, ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); mem_ready = 1'b0; #1;
    expect_all("lw.memrd0", 5, ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); expect_all("lw.memrd1", 5, ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); expect_all("lw.memrd2", 5, ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); mem_ready = 1'b1; #1;
    expect_all("lw.memrd3", 5, ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); expect_all("lw.memwb", 6, ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tick();
    $display("[TB] lw: 8 cycles with 3 wait states, back in state %0d", state);

    // beq taken, with one fetch wait cycle first
    op = 6'b000100; zero = 1'b1; mem_ready = 1'b0;
    #1;
    fetch_chk("beq.fetchwait", 0);
    tick();
    chk("beq.fetchhold.state", 32'(state), 0);
    mem_ready = 1'b1; #1;
    fetch_chk("beq.fetch", 1);
    tick(); decode_chk("beq.decode");
    tick(); expect_all("beq.branch", 8, SUB, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    zero = 1'b0; #1;
    chk("beq.nottaken.pcwrite", 32'(pc_write), 0);
    zero = 1'b1;
    tick();
    $display("[TB] beq: taken with Zero=1, state %0d", state);

    // bne with Zero=1 must not write the PC
    op = 6'b000101;
    #1;
    fetch_chk("bne.fetch", 1);
    tick(); decode_chk("bne.decode");
    tick(); expect_all("bne.branch", 8, SUB, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    zero = 1'b0; #1;
    chk("bne.taken.pcwrite", 32'(pc_write), 1);
    tick();
    $display("[TB] bne: not taken with Zero=1, state %0d", state);

    // sw, then reset during the memory wait abandons the write
    op = 6'b101011;
    #1;
    fetch_chk("sw.fetch", 1);
    tick(); decode_chk("sw.decode");
    tick(); expect_all("sw.memadr", 4, ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); mem_ready = 1'b0; #1;
    expect_all("sw.memwr", 7, ADD, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; #1;
    chk("sw.rst.memwrite", 32'(mem_write), 0);
    tick(); rst_n = 1'b1; mem_ready = 1'b1;
    op = 6'b001000;
    #1;
    fetch_chk("sw.rst.fetch", 1);
    $display("[TB] sw: reset during MEMWR wait, state %0d", state);

    // addi
    tick(); decode_chk("addi.decode");
    tick(); expect_all("addi.exec",  2, ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); expect_all("addi.aluwb", 3, ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    $display("[TB] addi: 4-cycle sequence, state %0d", state);

    // sll uses shamt as operand A
    op = 6'b000000; funct = 6'b000000;
    #1;
    fetch_chk("sll.fetch", 1);
    tick(); decode_chk("sll.decode");
    tick(); expect_all("sll.exec", 2, SLL, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); expect_all("sll.aluwb", 3, ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tick();
    $display("[TB] sll: shamt operand, state %0d", state);

    // jal
    op = 6'b000011;
    #1;
    fetch_chk("jal.fetch", 1);
    tick(); decode_chk("jal.decode");
    tick(); expect_all("jal.jump", 9, ADD, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 2, 0);
    tick();
    $display("[TB] jal: link to r31, state %0d", state);

    // jr
    op = 6'b000000; funct = 6'b001000;
    #1;
    fetch_chk("jr.fetch", 1);
    tick(); decode_chk("jr.decode");
    tick(); expect_all("jr.jump", 9, ADD, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0);
    tick();
    $display("[TB] jr: PC from rs, state %0d", state);

    // bgez (REGIMM, rt=1)
    op = 6'b000001; funct = 6'd0; rt = 5'd1; zero = 1'b1;
    #1;
    fetch_chk("bgez.fetch", 1);
    tick(); decode_chk("bgez.decode");
    tick();
`ifdef MULTI_CTRL_BRANCH_EXT_EN
    expect_all("bgez.branch", 8, BGEZ, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    tick();
`else
    expect_all("bgez.trap", 15, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    rt = 5'd0;
    $display("[TB] bgez: resolved, state %0d", state);

    // Illegal opcode traps until reset
    op = 6'b111111;
    #1;
    fetch_chk("ill.fetch", 1);
    tick(); decode_chk("ill.decode");
    tick(); expect_all("ill.trap",  15, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(); expect_all("ill.trap2", 15, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0; #1;
    chk("ill.rst.illegal", 32'(illegal), 0);
    tick();
    rst_n = 1'b1; op = 6'b000000; funct = 6'b100000;
    #1;
    fetch_chk("ill.recover", 1);
    $display("[TB] illegal: trapped then recovered, state %0d", state);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
